// File: rtl/imem_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_sequencer_if
//   Bus bundle between the instruction fetch sequencer, the byte-wide
//   instruction memory, the branch unit and decode.
//
//   master modport : the fetch sequencer
//   slave  modport : memory / branch unit / decode side
//
//   mem_addr, mem_rdata             byte read port (combinational read)
//   branch_valid, branch_target     redirect request
//   inst_valid, inst_ready          instruction handshake to decode
//   Instruction_Code, PC            presented instruction and its address
//   load_valid/addr/data/ready      program-load write request (IMEM_LOAD_EN)
//   mem_we, mem_wdata               memory write port (IMEM_LOAD_EN)
//
//   Build option: define IMEM_LOAD_EN to add the program-load write path.
// -----------------------------------------------------------------------------
interface imem_fetch_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              branch_valid;
   logic [ADDR_W-1:0] branch_target;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       Instruction_Code;
   logic [ADDR_W-1:0] PC;
`ifdef IMEM_LOAD_EN
   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;
   logic              load_ready;
   logic              mem_we;
   logic [7:0]        mem_wdata;
`endif

   modport master (
      output mem_addr,
      input  mem_rdata,
      input  branch_valid,
      input  branch_target,
      output inst_valid,
      input  inst_ready,
      output Instruction_Code,
      output PC
`ifdef IMEM_LOAD_EN
      ,
      input  load_valid,
      input  load_addr,
      input  load_data,
      output load_ready,
      output mem_we,
      output mem_wdata
`endif
   );

   modport slave (
      input  mem_addr,
      output mem_rdata,
      output branch_valid,
      output branch_target,
      input  inst_valid,
      output inst_ready,
      input  Instruction_Code,
      input  PC
`ifdef IMEM_LOAD_EN
      ,
      output load_valid,
      output load_addr,
      output load_data,
      input  load_ready,
      input  mem_we,
      input  mem_wdata
`endif
   );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// imem_fetch_sequencer
//   Fetch front-end for a byte-wide, big-endian instruction memory. Reads the
//   four bytes of an instruction on consecutive cycles, assembles them (byte at
//   PC lands in [31:24]) and holds the word for decode on a valid/ready
//   handshake. Supports branch redirect and PC wrap-around.
//
//   Parameters
//     ADDR_W    byte-address width of the instruction memory
//     RESET_PC  fetch address after reset (multiple of 4)
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-low reset
//     bus    imem_fetch_sequencer_if.master (memory read port, branch
//            redirect, decode handshake, optional load write port)
//
//   Build option: define IMEM_LOAD_EN to arbitrate a program-load byte write
//   port into the same memory. Without it the memory is read-only.
// -----------------------------------------------------------------------------
module imem_fetch_sequencer #(
   parameter int ADDR_W   = 10,
   parameter int RESET_PC = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   imem_fetch_sequencer_if.master bus
);

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]        state_q;
   logic [1:0]        byte_cnt_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [23:0]       asm_q;        // first three bytes of the word in flight
   logic              inst_valid_q;
   logic [31:0]       code_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              handshake;
   logic              load_accept;

   assign handshake = inst_valid_q & bus.inst_ready;

`ifdef IMEM_LOAD_EN
   logic load_ready;

   // A load may only steal the port where no fetch byte is lost: in HOLD, or
   // before the first byte of a word. A pending branch owns the cycle.
   assign load_ready  = reset && !bus.branch_valid &&
                        ((state_q == HOLD) || ((state_q == FETCH) && (byte_cnt_q == 2'd0)));
   assign load_accept = bus.load_valid & load_ready;

   assign bus.load_ready = load_ready;
   assign bus.mem_we     = load_accept;
   assign bus.mem_wdata  = load_accept ? bus.load_data : 8'h00;
`else
   assign load_accept = 1'b0;
`endif

   // Memory address: byte within the word while fetching, the word base while
   // holding, the load address when a write is accepted.
   always_comb begin
      mem_addr_d = fetch_pc_q;
      if (state_q == FETCH) mem_addr_d = fetch_pc_q + ADDR_W'(byte_cnt_q);
`ifdef IMEM_LOAD_EN
      if (load_accept) mem_addr_d = bus.load_addr;
`endif
   end

   assign bus.mem_addr         = mem_addr_d;
   assign bus.inst_valid       = inst_valid_q;
   assign bus.Instruction_Code = code_q;
   assign bus.PC               = pc_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= FETCH;
         byte_cnt_q   <= 2'd0;
         fetch_pc_q   <= RST_PC;
         asm_q        <= 24'h0;
         inst_valid_q <= 1'b0;
         code_q       <= 32'h0;
         pc_q         <= RST_PC;
      end else if (bus.branch_valid) begin
         // Redirect drops any partial word and any held word, even one being
         // accepted this cycle; the target is forced word-aligned.
         state_q      <= FETCH;
         byte_cnt_q   <= 2'd0;
         fetch_pc_q   <= {bus.branch_target[ADDR_W-1:2], 2'b00};
         inst_valid_q <= 1'b0;
      end else if (!load_accept) begin
         // An accepted load freezes the sequencer for one cycle.
         if (state_q == FETCH) begin
            asm_q <= {asm_q[15:0], bus.mem_rdata};
            if (byte_cnt_q == 2'd3) begin
               code_q       <= {asm_q, bus.mem_rdata};
               pc_q         <= fetch_pc_q;
               inst_valid_q <= 1'b1;
               byte_cnt_q   <= 2'd0;
               state_q      <= HOLD;
            end else begin
               byte_cnt_q <= byte_cnt_q + 2'd1;
            end
         end else if (handshake) begin
            inst_valid_q <= 1'b0;
            fetch_pc_q   <= fetch_pc_q + ADDR_W'(4);
            byte_cnt_q   <= 2'd0;
            state_q      <= FETCH;
         end
      end
   end

endmodule
